// File: rtl/apb_master_interface_pkg.sv
// Shared types and address map for the APB master bridge.
// The address map decodes the 4 KiB page number held in addr[31:12].
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef enum logic [2:0] {
        SLV_RAM,
        SLV_GPO,
        SLV_GPI,
        SLV_GPIO,
        SLV_NONE
    } slv_e;

    localparam logic [19:0] RAM_BASE  = 20'h10000;
    localparam logic [19:0] GPO_BASE  = 20'h10001;
    localparam logic [19:0] GPI_BASE  = 20'h10002;
    localparam logic [19:0] GPIO_BASE = 20'h10003;

    function automatic slv_e addr_decode(input logic [19:0] page);
        slv_e s;
        case (page)
            RAM_BASE:  s = SLV_RAM;
            GPO_BASE:  s = SLV_GPO;
            GPI_BASE:  s = SLV_GPI;
            GPIO_BASE: s = SLV_GPIO;
            default:   s = SLV_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/apb_master_interface_if.sv
// CPU req/ready bus plus the four-slave APB3 bus of the bridge.
// The master modport is the bridge's view; slave is the peripheral/CPU side.
interface apb_master_interface_if;

    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PENABLE;
    logic        PSEL_RAM;
    logic        PSEL_GPO;
    logic        PSEL_GPI;
    logic        PSEL_GPIO;
    logic [31:0] PRDATA_RAM;
    logic [31:0] PRDATA_GPO;
    logic [31:0] PRDATA_GPI;
    logic [31:0] PRDATA_GPIO;
    logic        PREADY_RAM;
    logic        PREADY_GPO;
    logic        PREADY_GPI;
    logic        PREADY_GPIO;

    modport master (
        input  req, write, addr, wdata,
        output rdata, ready,
        output PADDR, PWRITE, PWDATA, PENABLE,
        output PSEL_RAM, PSEL_GPO, PSEL_GPI, PSEL_GPIO,
        input  PRDATA_RAM, PRDATA_GPO, PRDATA_GPI, PRDATA_GPIO,
        input  PREADY_RAM, PREADY_GPO, PREADY_GPI, PREADY_GPIO
    );

    modport slave (
        output req, write, addr, wdata,
        input  rdata, ready,
        input  PADDR, PWRITE, PWDATA, PENABLE,
        input  PSEL_RAM, PSEL_GPO, PSEL_GPI, PSEL_GPIO,
        output PRDATA_RAM, PRDATA_GPO, PRDATA_GPI, PRDATA_GPIO,
        output PREADY_RAM, PREADY_GPO, PREADY_GPI, PREADY_GPIO
    );

endinterface

// File: rtl/apb_master_interface_decoder.sv
// Page decode to one-hot select and slave index, plus PREADY/PRDATA return mux.
// Only the selected slave's signals reach the outputs, so X on idle slaves is blocked.
module apb_addr_decoder
    import apb_pkg::*;
(
    input  logic [19:0] page_i,
    input  logic [31:0] prdata_ram_i,
    input  logic [31:0] prdata_gpo_i,
    input  logic [31:0] prdata_gpi_i,
    input  logic [31:0] prdata_gpio_i,
    input  logic        pready_ram_i,
    input  logic        pready_gpo_i,
    input  logic        pready_gpi_i,
    input  logic        pready_gpio_i,
    output logic [3:0]  sel_o,
    output slv_e        slv_o,
    output logic        ready_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        slv_o   = addr_decode(page_i);
        sel_o   = '0;
        ready_o = 1'b0;
        rdata_o = '0;
        case (slv_o)
            SLV_RAM:  begin sel_o[0] = 1'b1; ready_o = pready_ram_i;  rdata_o = prdata_ram_i;  end
            SLV_GPO:  begin sel_o[1] = 1'b1; ready_o = pready_gpo_i;  rdata_o = prdata_gpo_i;  end
            SLV_GPI:  begin sel_o[2] = 1'b1; ready_o = pready_gpi_i;  rdata_o = prdata_gpi_i;  end
            SLV_GPIO: begin sel_o[3] = 1'b1; ready_o = pready_gpio_i; rdata_o = prdata_gpio_i; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/apb_master_interface.sv
// Single-outstanding APB3 master: CPU req/ready -> RAM/GPO/GPI/GPIO slaves.
// Define APB_TIMEOUT_EN to bound ACCESS at TIMEOUT_CYCLES cycles (ready with 0xDEADBEEF).
module apb_master_interface
    import apb_pkg::*;
`ifdef APB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb_master_interface_if.master bus
);

    apb_state_e  state_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        pwrite_q;
    logic        penable_q;

    logic [3:0]  dec_sel;
    slv_e        dec_slv;
    logic        dec_ready;
    logic [31:0] dec_rdata;
    logic        done;
    logic [31:0] rdata;

    apb_addr_decoder u_decoder (
        .page_i        (paddr_q[31:12]),
        .prdata_ram_i  (bus.PRDATA_RAM),
        .prdata_gpo_i  (bus.PRDATA_GPO),
        .prdata_gpi_i  (bus.PRDATA_GPI),
        .prdata_gpio_i (bus.PRDATA_GPIO),
        .pready_ram_i  (bus.PREADY_RAM),
        .pready_gpo_i  (bus.PREADY_GPO),
        .pready_gpi_i  (bus.PREADY_GPI),
        .pready_gpio_i (bus.PREADY_GPIO),
        .sel_o         (dec_sel),
        .slv_o         (dec_slv),
        .ready_o       (dec_ready),
        .rdata_o       (dec_rdata)
    );

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] TimeoutRdata = 32'hDEAD_BEEF;
    logic [CntW-1:0] cnt_q;
    logic            timed_out;

    // Counts completed ACCESS cycles; fires in the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timed_out = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK) begin
        if (!PRESET || state_q != ACCESS) cnt_q <= '0;
        else                              cnt_q <= cnt_q + 1'b1;
    end
`endif

    always_comb begin
        done  = 1'b0;
        rdata = '0;
        if (state_q == ACCESS) begin
            if (dec_slv == SLV_NONE || dec_ready) begin
                done  = 1'b1;
                rdata = dec_rdata;
            end
`ifdef APB_TIMEOUT_EN
            else if (timed_out) begin
                done  = 1'b1;
                rdata = TimeoutRdata;
            end
`endif
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    penable_q <= 1'b0;
                    if (bus.req) begin
                        paddr_q  <= bus.addr;
                        pwdata_q <= bus.wdata;
                        pwrite_q <= bus.write;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    // Selects come from registered PADDR and state only, so they change on clock edges.
    assign bus.PSEL_RAM  = (state_q != IDLE) && dec_sel[0];
    assign bus.PSEL_GPO  = (state_q != IDLE) && dec_sel[1];
    assign bus.PSEL_GPI  = (state_q != IDLE) && dec_sel[2];
    assign bus.PSEL_GPIO = (state_q != IDLE) && dec_sel[3];

    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PENABLE = penable_q;
    assign bus.ready   = done;
    assign bus.rdata   = rdata;

endmodule

// File: tb/tb_apb_master_interface.sv
// Directed bench for apb_master_interface: RAM write, GPI wait states, unmapped,
// ignored req, reset mid-ACCESS, and timeout behaviour for either build.
module tb_apb_master_interface;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    apb_master_interface_if bus ();

    apb_master_interface dut (
        .PCLK   (clk),
        .PRESET (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] psel_vec();
        return {28'b0, bus.PSEL_GPIO, bus.PSEL_GPI, bus.PSEL_GPO, bus.PSEL_RAM};
    endfunction

    task automatic start_req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        bus.req   = 1'b1;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = wd;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.req = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.PRDATA_RAM = '0; bus.PRDATA_GPO = '0; bus.PRDATA_GPI = '0; bus.PRDATA_GPIO = '0;
        bus.PREADY_RAM = 1'b0; bus.PREADY_GPO = 1'b0; bus.PREADY_GPI = 1'b0; bus.PREADY_GPIO = 1'b0;

        tick(); tick();
        check("rst_paddr",   bus.PADDR, 32'h0);
        check("rst_pwdata",  bus.PWDATA, 32'h0);
        check("rst_pwrite",  {31'b0, bus.PWRITE}, 32'h0);
        check("rst_penable", {31'b0, bus.PENABLE}, 32'h0);
        check("rst_psel",    psel_vec(), 32'h0);
        check("rst_ready",   {31'b0, bus.ready}, 32'h0);
        check("rst_rdata",   bus.rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // RAM write, zero wait states
        start_req(1'b1, 32'h1000_0000, 32'h0000_1111);
        bus.PREADY_RAM = 1'b1;
        tick();
        bus.req = 1'b0;
        #1;
        check("ram_setup_psel",    psel_vec(), 32'h1);
        check("ram_setup_penable", {31'b0, bus.PENABLE}, 32'h0);
        check("ram_setup_pwdata",  bus.PWDATA, 32'h0000_1111);
        check("ram_setup_pwrite",  {31'b0, bus.PWRITE}, 32'h1);
        check("ram_setup_ready",   {31'b0, bus.ready}, 32'h0);
        tick();
        check("ram_access_penable", {31'b0, bus.PENABLE}, 32'h1);
        check("ram_access_psel",    psel_vec(), 32'h1);
        check("ram_access_ready",   {31'b0, bus.ready}, 32'h1);
        tick();
        check("ram_done_ready",   {31'b0, bus.ready}, 32'h0);
        check("ram_done_penable", {31'b0, bus.PENABLE}, 32'h0);
        check("ram_done_psel",    psel_vec(), 32'h0);
        bus.PREADY_RAM = 1'b0;

        // GPI read, 3 wait states, X on an unselected slave
        bus.PREADY_RAM  = 1'bx;
        bus.PRDATA_RAM  = 'x;
        bus.PRDATA_GPI  = 32'hA5A5_0001;
        start_req(1'b0, 32'h1000_2004, 32'h0);
        tick();
        bus.req = 1'b0;
        #1;
        check("gpi_setup_psel",  psel_vec(), 32'h4);
        check("gpi_setup_paddr", bus.PADDR, 32'h1000_2004);
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gpi_wait%0d_ready", i),   {31'b0, bus.ready}, 32'h0);
            check($sformatf("gpi_wait%0d_rdata", i),   bus.rdata, 32'h0);
            check($sformatf("gpi_wait%0d_penable", i), {31'b0, bus.PENABLE}, 32'h1);
            check($sformatf("gpi_wait%0d_paddr", i),   bus.PADDR, 32'h1000_2004);
            check($sformatf("gpi_wait%0d_psel", i),    psel_vec(), 32'h4);
            tick();
        end
        bus.PREADY_GPI = 1'b1;
        #1;
        check("gpi_ready", {31'b0, bus.ready}, 32'h1);
        check("gpi_rdata", bus.rdata, 32'hA5A5_0001);
        tick();
        check("gpi_after_ready", {31'b0, bus.ready}, 32'h0);
        check("gpi_after_rdata", bus.rdata, 32'h0);
        bus.PREADY_GPI = 1'b0;
        bus.PREADY_RAM = 1'b0;
        bus.PRDATA_RAM = 32'h1234_5678;

        // Unmapped read completes without any select
        start_req(1'b0, 32'h2000_0000, 32'h0);
        tick();
        bus.req = 1'b0;
        #1;
        check("unm_setup_psel",  psel_vec(), 32'h0);
        check("unm_setup_ready", {31'b0, bus.ready}, 32'h0);
        tick();
        check("unm_access_psel",  psel_vec(), 32'h0);
        check("unm_access_ready", {31'b0, bus.ready}, 32'h1);
        check("unm_access_rdata", bus.rdata, 32'h0);
        tick();
        check("unm_done_ready", {31'b0, bus.ready}, 32'h0);

        // req during ACCESS and during the ready cycle is dropped
        start_req(1'b1, 32'h1000_1000, 32'h0000_00AA);
        tick();
        bus.req = 1'b0;
        tick();
        start_req(1'b0, 32'h1000_3000, 32'h0);
        tick();
        check("ign_paddr",  bus.PADDR, 32'h1000_1000);
        check("ign_psel",   psel_vec(), 32'h2);
        check("ign_pwrite", {31'b0, bus.PWRITE}, 32'h1);
        bus.PREADY_GPO = 1'b1;
        #1;
        check("ign_ready", {31'b0, bus.ready}, 32'h1);
        tick();
        bus.req = 1'b0;
        bus.PREADY_GPO = 1'b0;
        #1;
        check("ign_idle_psel",  psel_vec(), 32'h0);
        check("ign_idle_paddr", bus.PADDR, 32'h1000_1000);
        tick();
        check("ign_still_idle", psel_vec(), 32'h0);

        // Reset while in ACCESS on GPIO
        start_req(1'b1, 32'h1000_3008, 32'h0000_CAFE);
        tick();
        bus.req = 1'b0;
        tick();
        check("gpio_access_psel",    psel_vec(), 32'h8);
        check("gpio_access_penable", {31'b0, bus.PENABLE}, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.PREADY_GPIO = 1'b1;
        #1;
        check("rstacc_psel",    psel_vec(), 32'h0);
        check("rstacc_penable", {31'b0, bus.PENABLE}, 32'h0);
        check("rstacc_paddr",   bus.PADDR, 32'h0);
        check("rstacc_pwdata",  bus.PWDATA, 32'h0);
        check("rstacc_pwrite",  {31'b0, bus.PWRITE}, 32'h0);
        check("rstacc_ready",   {31'b0, bus.ready}, 32'h0);
        tick();
        check("rstacc_idle_ready", {31'b0, bus.ready}, 32'h0);
        bus.PREADY_GPIO = 1'b0;

        // RAM read with PREADY held low
        start_req(1'b0, 32'h1000_0010, 32'h0);
        tick();
        bus.req = 1'b0;
        tick();
`ifdef APB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            check($sformatf("to_wait%0d_ready", i), {31'b0, bus.ready}, 32'h0);
            tick();
        end
        check("to_ready", {31'b0, bus.ready}, 32'h1);
        check("to_rdata", bus.rdata, 32'hDEAD_BEEF);
        tick();
        check("to_after_ready", {31'b0, bus.ready}, 32'h0);
        check("to_after_psel",  psel_vec(), 32'h0);
`else
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("hold%0d_ready", i), {31'b0, bus.ready}, 32'h0);
            tick();
        end
        check("hold_psel", psel_vec(), 32'h1);
        bus.PREADY_RAM = 1'b1;
        #1;
        check("hold_release_ready", {31'b0, bus.ready}, 32'h1);
        check("hold_release_rdata", bus.rdata, 32'h1234_5678);
        tick();
        bus.PREADY_RAM = 1'b0;
        check("hold_after_ready", {31'b0, bus.ready}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
